// File: rtl/dct_pkg.sv
// Shared constants and loader state encoding for the 32-point DCT datapath.
package dct_pkg;

  localparam int unsigned DCT_N       = 32;
  localparam int unsigned DCT_CNT_W   = 5;
  localparam int unsigned DCT_WIDTH_X = 16;

  typedef enum logic {
    LDR_FILL = 1'b0,
    LDR_FULL = 1'b1
  } ldr_state_e;

endpackage

// File: rtl/dct_sample_bank.sv
// 32-entry sample register bank: one indexed write port, all entries readable in parallel.
module dct_sample_bank
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH_X = DCT_WIDTH_X
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [DCT_CNT_W-1:0]       waddr,
  input  logic [WIDTH_X-1:0]         wdata,
  output logic [DCT_N*WIDTH_X-1:0]   rdata
);

  logic [WIDTH_X-1:0] mem [DCT_N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DCT_N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < DCT_N; g++) begin : g_rd
    assign rdata[g*WIDTH_X +: WIDTH_X] = mem[g];
  end

endmodule

// File: rtl/dct32_input_loader.sv
// Streams samples into a collection bank and hands complete 32-sample vectors to the DCT stage.
// Optional input level shift (unsigned -> two's complement) enabled by DCT32_LOADER_LEVEL_SHIFT_EN.
module dct32_input_loader
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH_X = DCT_WIDTH_X
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_X-1:0] in_data,
  input  logic               in_last,
  input  logic               dct_ready,
  output logic [WIDTH_X-1:0] x0,
  output logic [WIDTH_X-1:0] x1,
  output logic [WIDTH_X-1:0] x2,
  output logic [WIDTH_X-1:0] x3,
  output logic [WIDTH_X-1:0] x4,
  output logic [WIDTH_X-1:0] x5,
  output logic [WIDTH_X-1:0] x6,
  output logic [WIDTH_X-1:0] x7,
  output logic [WIDTH_X-1:0] x8,
  output logic [WIDTH_X-1:0] x9,
  output logic [WIDTH_X-1:0] x10,
  output logic [WIDTH_X-1:0] x11,
  output logic [WIDTH_X-1:0] x12,
  output logic [WIDTH_X-1:0] x13,
  output logic [WIDTH_X-1:0] x14,
  output logic [WIDTH_X-1:0] x15,
  output logic [WIDTH_X-1:0] x16,
  output logic [WIDTH_X-1:0] x17,
  output logic [WIDTH_X-1:0] x18,
  output logic [WIDTH_X-1:0] x19,
  output logic [WIDTH_X-1:0] x20,
  output logic [WIDTH_X-1:0] x21,
  output logic [WIDTH_X-1:0] x22,
  output logic [WIDTH_X-1:0] x23,
  output logic [WIDTH_X-1:0] x24,
  output logic [WIDTH_X-1:0] x25,
  output logic [WIDTH_X-1:0] x26,
  output logic [WIDTH_X-1:0] x27,
  output logic [WIDTH_X-1:0] x28,
  output logic [WIDTH_X-1:0] x29,
  output logic [WIDTH_X-1:0] x30,
  output logic [WIDTH_X-1:0] x31,
  output logic               load,
  output logic               frame_err
);

  localparam logic [DCT_CNT_W-1:0] LAST_SLOT = DCT_CNT_W'(DCT_N - 1);

  ldr_state_e                 state;
  logic [DCT_CNT_W-1:0]       cnt;
  logic [WIDTH_X-1:0]         wdata;
  logic [DCT_N*WIDTH_X-1:0]   coll_flat;
  logic [WIDTH_X-1:0]         xo [DCT_N];
  logic                       accept;
  logic                       xfer;

  // Ready is held low during reset; a pending vector only blocks input while downstream stalls.
  assign in_ready = rst && ((state == LDR_FILL) || dct_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = (state == LDR_FULL) && dct_ready;

`ifdef DCT32_LOADER_LEVEL_SHIFT_EN
  assign wdata = in_data ^ {1'b1, {(WIDTH_X-1){1'b0}}};
`else
  assign wdata = in_data;
`endif

  dct_sample_bank #(.WIDTH_X(WIDTH_X)) u_coll (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (cnt),
    .wdata (wdata),
    .rdata (coll_flat)
  );

  // Transfer reads the bank before this edge's slot-0 write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LDR_FILL;
      cnt       <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < DCT_N; i++) xo[i] <= '0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      if (xfer) begin
        for (int i = 0; i < DCT_N; i++) xo[i] <= coll_flat[i*WIDTH_X +: WIDTH_X];
        load  <= 1'b1;
        state <= LDR_FILL;
      end
      if (accept) begin
        if (cnt == LAST_SLOT) begin
          cnt       <= '0;
          state     <= LDR_FULL;
          frame_err <= !in_last;
        end else if (in_last) begin
          cnt       <= '0;
          frame_err <= 1'b1;
        end else begin
          cnt <= cnt + DCT_CNT_W'(1);
        end
      end
    end
  end

  assign x0  = xo[0];
  assign x1  = xo[1];
  assign x2  = xo[2];
  assign x3  = xo[3];
  assign x4  = xo[4];
  assign x5  = xo[5];
  assign x6  = xo[6];
  assign x7  = xo[7];
  assign x8  = xo[8];
  assign x9  = xo[9];
  assign x10 = xo[10];
  assign x11 = xo[11];
  assign x12 = xo[12];
  assign x13 = xo[13];
  assign x14 = xo[14];
  assign x15 = xo[15];
  assign x16 = xo[16];
  assign x17 = xo[17];
  assign x18 = xo[18];
  assign x19 = xo[19];
  assign x20 = xo[20];
  assign x21 = xo[21];
  assign x22 = xo[22];
  assign x23 = xo[23];
  assign x24 = xo[24];
  assign x25 = xo[25];
  assign x26 = xo[26];
  assign x27 = xo[27];
  assign x28 = xo[28];
  assign x29 = xo[29];
  assign x30 = xo[30];
  assign x31 = xo[31];

endmodule

// File: tb/tb_dct32_input_loader.sv
// Self-checking bench for dct32_input_loader: directed scenarios plus random traffic against a queue model.
module tb_dct32_input_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        dct_ready = 1'b0;
  logic [15:0] xs [32];
  logic        load;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: samples of the vector being collected, one complete vector awaiting hand-off,
  // and the vector currently visible on x0..x31.
  logic [15:0] partial [$];
  logic [15:0] pend_vec [32];
  logic [15:0] held [32];
  logic        pending = 1'b0;

  int cyc = 0;
  int load_cyc [$];
  int load_x0 [$];
  int ferr_cnt = 0;
  int rdy_low_cnt = 0;

  always #5 clk = ~clk;

  dct32_input_loader #(.WIDTH_X(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dct_ready(dct_ready),
    .x0(xs[0]),   .x1(xs[1]),   .x2(xs[2]),   .x3(xs[3]),
    .x4(xs[4]),   .x5(xs[5]),   .x6(xs[6]),   .x7(xs[7]),
    .x8(xs[8]),   .x9(xs[9]),   .x10(xs[10]), .x11(xs[11]),
    .x12(xs[12]), .x13(xs[13]), .x14(xs[14]), .x15(xs[15]),
    .x16(xs[16]), .x17(xs[17]), .x18(xs[18]), .x19(xs[19]),
    .x20(xs[20]), .x21(xs[21]), .x22(xs[22]), .x23(xs[23]),
    .x24(xs[24]), .x25(xs[25]), .x26(xs[26]), .x27(xs[27]),
    .x28(xs[28]), .x29(xs[29]), .x30(xs[30]), .x31(xs[31]),
    .load(load), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] level_shift(input logic [15:0] d);
`ifdef DCT32_LOADER_LEVEL_SHIFT_EN
    return 16'((32'(d) + 32'h10000 - 32'h8000) % 32'h10000);
`else
    return d;
`endif
  endfunction

  function automatic void clear_stats();
    load_cyc.delete();
    load_x0.delete();
    ferr_cnt = 0;
    rdy_low_cnt = 0;
  endfunction

  // One clock cycle: drive at negedge, check ready, advance the model, check registered outputs after the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic dr);
    logic exp_rdy, acc, nload, nerr;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; dct_ready = dr;
    #1;
    exp_rdy = !pending || dr;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!in_ready) rdy_low_cnt++;
    acc = v && exp_rdy;
    nload = 1'b0;
    nerr = 1'b0;
    if (pending && dr) begin
      held = pend_vec;
      nload = 1'b1;
      pending = 1'b0;
    end
    if (acc) begin
      partial.push_back(level_shift(d));
      if (partial.size() == 32) begin
        for (int i = 0; i < 32; i++) pend_vec[i] = partial[i];
        pending = 1'b1;
        partial.delete();
        nerr = !l;
      end else if (l) begin
        nerr = 1'b1;
        partial.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("load", 32'(load), 32'(nload));
    chk("frame_err", 32'(frame_err), 32'(nerr));
    if (load) begin
      load_cyc.push_back(cyc);
      load_x0.push_back(int'(xs[0]));
    end
    if (frame_err) ferr_cnt++;
    for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), 32'(xs[i]), 32'(held[i]));
  endtask

  // Assert reset for n cycles with traffic offered, checking the cleared outputs.
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; dct_ready = 1'b1; in_last = 1'b0;
    partial.delete();
    pending = 1'b0;
    for (int i = 0; i < 32; i++) held[i] = '0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_x%0d", i), 32'(xs[i]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int base, input logic dr, input logic with_last);
    for (int i = 0; i < n; i++)
      step(1'b1, 16'(base + i), with_last && ((i % 32) == 31), dr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      held[i] = '0;
      pend_vec[i] = '0;
    end

    // Reset, partial stream, reset mid-vector, then one clean vector 1..32.
    apply_reset(3);
    feed(10, 500, 1'b1, 1'b1);
    apply_reset(3);
    clear_stats();
    feed(32, 1, 1'b1, 1'b1);
    idle(2);
    chk("s1_loads", 32'(load_cyc.size()), 32'd1);
    chk("s1_x0", 32'(xs[0]), 32'(level_shift(16'd1)));
    chk("s1_x31", 32'(xs[31]), 32'(level_shift(16'd32)));

    // Back-to-back 96 samples at full rate.
    clear_stats();
    feed(96, 1, 1'b1, 1'b1);
    idle(2);
    chk("b2b_loads", 32'(load_cyc.size()), 32'd3);
    chk("b2b_ready_drops", 32'(rdy_low_cnt), 32'd0);
    if (load_cyc.size() >= 3) begin
      chk("b2b_gap1", 32'(load_cyc[1] - load_cyc[0]), 32'd32);
      chk("b2b_gap2", 32'(load_cyc[2] - load_cyc[1]), 32'd32);
      chk("b2b_vec2_x0", 32'(load_x0[1]), 32'(level_shift(16'd33)));
    end

    // Downstream stall for 5 cycles after a completed vector.
    clear_stats();
    feed(32, 200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'd300, 1'b0, 1'b0);
    chk("bp_stall_cycles", 32'(rdy_low_cnt), 32'd5);
    chk("bp_no_load_in_stall", 32'(load_cyc.size()), 32'd0);
    feed(32, 300, 1'b1, 1'b1);
    idle(2);
    chk("bp_loads", 32'(load_cyc.size()), 32'd2);
    if (load_cyc.size() >= 2) begin
      chk("bp_vec1_x0", 32'(load_x0[0]), 32'(level_shift(16'd200)));
      chk("bp_vec2_x0", 32'(load_x0[1]), 32'(level_shift(16'd300)));
    end

    // Early in_last on the 10th sample discards it; next vector 100..131.
    clear_stats();
    for (int i = 0; i < 10; i++) step(1'b1, 16'(50 + i), i == 9, 1'b1);
    feed(32, 100, 1'b1, 1'b1);
    idle(2);
    chk("early_ferr", 32'(ferr_cnt), 32'd1);
    chk("early_loads", 32'(load_cyc.size()), 32'd1);
    chk("early_x0", 32'(xs[0]), 32'(level_shift(16'd100)));

    // Missing in_last on slot 31: error flagged, vector still delivered.
    clear_stats();
    feed(32, 400, 1'b1, 1'b0);
    idle(2);
    chk("miss_ferr", 32'(ferr_cnt), 32'd1);
    chk("miss_loads", 32'(load_cyc.size()), 32'd1);
    chk("miss_x31", 32'(xs[31]), 32'(level_shift(16'd431)));

`ifdef DCT32_LOADER_LEVEL_SHIFT_EN
    step(1'b1, 16'h8000, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 1'b0, 1'b1);
    for (int i = 2; i < 32; i++) step(1'b1, 16'(i), i == 31, 1'b1);
    idle(2);
    chk("ls_x0", 32'(xs[0]), 32'h0000);
    chk("ls_x1", 32'(xs[1]), 32'h8000);
`endif

    // Random traffic with random backpressure and occasional framing errors.
    for (int n = 0; n < 600; n++) begin
      logic v, dr, l;
      v  = $urandom_range(0, 9) < 8;
      dr = $urandom_range(0, 9) < 7;
      if (partial.size() == 31) l = ($urandom_range(0, 9) != 0);
      else                      l = ($urandom_range(0, 39) == 0);
      step(v, 16'($urandom), l, dr);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
